// File: rtl/exec_trace_buffer.sv
// Triggered execution-trace capture buffer: a ring of retired-instruction records
// that freezes POST_TRIG records after a trigger and then drains oldest-first.
module exec_trace_buffer #(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int XLEN      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       rec_valid,
    input  logic [XLEN-1:0]            rec_pc,
    input  logic [XLEN-1:0]            rec_inst,
    input  logic [XLEN-1:0]            rec_wdata,
    input  logic [7:0]                 trig_op,
    input  logic [7:0]                 trig_op_mask,
    input  logic                       trig_pc_en,
    input  logic [XLEN-1:0]            trig_pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_inst,
    output logic [XLEN-1:0]            rd_wdata,
    output logic                       rd_last,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    localparam logic [FW-1:0] L_DEPTH  = FW'(DEPTH);
    localparam logic [FW-1:0] L_POST   = FW'(POST_TRIG);
    localparam logic [FW-1:0] L_FONE   = FW'(1);
    localparam logic [FW-1:0] L_FZERO  = FW'(0);
    localparam logic [AW-1:0] L_AONE   = AW'(1);
    localparam logic [AW-1:0] L_AZERO  = AW'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   w_wp_nx;
    logic [AW-1:0]   r_rp;
    logic [AW-1:0]   w_rp_nx;
    logic [FW-1:0]   r_fill;
    logic [FW-1:0]   w_fill_nx;
    logic [FW-1:0]   r_post_cnt;
    logic [FW-1:0]   w_post_cnt_nx;
    logic            r_rd_valid;
    logic            r_rd_last;
    logic            w_hit;
    logic            w_we;
    logic            w_pop;

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [XLEN-1:0] r_mem_inst  [DEPTH];
    logic [XLEN-1:0] r_mem_wdata [DEPTH];

    assign w_hit = rec_valid
                 & (((rec_inst[7:0] ^ trig_op) & trig_op_mask) == 8'h00)
                 & (~trig_pc_en | (rec_pc == trig_pc));

    assign w_pop = r_rd_valid & rd_ready;

    // Next-state, pointer and fill computation; arm overrides every state.
    always_comb begin
        w_state_nx    = r_state;
        w_wp_nx       = r_wp;
        w_rp_nx       = r_rp;
        w_fill_nx     = r_fill;
        w_post_cnt_nx = r_post_cnt;
        w_we          = 1'b0;

        if (arm) begin
            w_state_nx    = S_ARMED;
            w_wp_nx       = L_AZERO;
            w_fill_nx     = L_FZERO;
            w_post_cnt_nx = L_FZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_IDLE;
                end
                S_ARMED: begin
                    if (rec_valid) begin
                        w_we    = 1'b1;
                        w_wp_nx = r_wp + L_AONE;
                        if (r_fill == L_DEPTH) begin
                            w_fill_nx = r_fill;
                        end else begin
                            w_fill_nx = r_fill + L_FONE;
                        end
                        if (w_hit) begin
                            w_post_cnt_nx = L_POST;
                            w_state_nx    = (POST_TRIG == 0) ? S_DONE : S_POST;
                        end else begin
                            w_state_nx = S_ARMED;
                        end
                    end else begin
                        w_state_nx = S_ARMED;
                    end
                end
                S_POST: begin
                    if (rec_valid) begin
                        w_we          = 1'b1;
                        w_wp_nx       = r_wp + L_AONE;
                        w_post_cnt_nx = r_post_cnt - L_FONE;
                        if (r_fill == L_DEPTH) begin
                            w_fill_nx = r_fill;
                        end else begin
                            w_fill_nx = r_fill + L_FONE;
                        end
                        if (r_post_cnt == L_FONE) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_POST;
                        end
                    end else begin
                        w_state_nx = S_POST;
                    end
                end
                S_DONE: begin
                    if (w_pop) begin
                        w_rp_nx   = r_rp + L_AONE;
                        w_fill_nx = r_fill - L_FONE;
                        if (r_fill == L_FONE) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_DONE;
                        end
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end

        // The oldest record sits fill entries behind the write pointer; DEPTH wraps to 0.
        if ((w_state_nx == S_DONE) && (r_state != S_DONE)) begin
            w_rp_nx = w_wp_nx - w_fill_nx[AW-1:0];
        end else begin
            w_rp_nx = w_rp_nx;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wp       <= L_AZERO;
            r_rp       <= L_AZERO;
            r_fill     <= L_FZERO;
            r_post_cnt <= L_FZERO;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wp       <= w_wp_nx;
            r_rp       <= w_rp_nx;
            r_fill     <= w_fill_nx;
            r_post_cnt <= w_post_cnt_nx;
            r_rd_valid <= (w_state_nx == S_DONE) && (w_fill_nx != L_FZERO);
            r_rd_last  <= (w_state_nx == S_DONE) && (w_fill_nx == L_FONE);
        end
    end

    // Record storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_pc[r_wp]    <= rec_pc;
            r_mem_inst[r_wp]  <= rec_inst;
            r_mem_wdata[r_wp] <= rec_wdata;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign rd_pc    = r_rd_valid ? r_mem_pc[r_rp]    : {XLEN{1'b0}};
    assign rd_inst  = r_rd_valid ? r_mem_inst[r_rp]  : {XLEN{1'b0}};
    assign rd_wdata = r_rd_valid ? r_mem_wdata[r_rp] : {XLEN{1'b0}};
    assign state    = r_state;
    assign fill     = r_fill;

endmodule
